ray_column_scheduler: RTL and testbench
=======================================

// Module: ray_column_scheduler
// PURPOSE
//  Sequences the per-column raycast for the 3D view. On each frame_start it requests one
//  ray per screen column from the ray engine and writes {shade,half_height} into a
//  double-buffered column RAM. The color mapper reads that RAM as memdata: [11:8] shade,
//  [7:0] half height.
//  Banks swap only at a frame boundary, so the display never shows a partly built frame.
// PARAMETERS
//  NUM_COLS   640     columns cast per frame; column index 0..NUM_COLS-1
//  COL_W      10      column index width
//  MAX_HALF   8'd239  clamp for half height; keeps Y_Center-height >= 1
// PORTS
//  Clk          in   1      system clock
//  reset_n      in   1      asynchronous, active-low reset
//  frame_start  in   1      one-cycle pulse at vsync, from the VGA controller
//  ray_req      out  1      request: cast the ray for column ray_col
//  ray_col      out  COL_W  column being requested; stable while ray_req=1
//  ray_ack      in   1      one-cycle pulse: ray_height and ray_shade are valid
//  ray_height   in   8      half wall height for ray_col
//  ray_shade    in   4      wall shade for ray_col
//  wr_en        out  1      column RAM write strobe
//  wr_addr      out  COL_W+1  {bank,col}
//  wr_data      out  12     {shade, clamped height}
//  rd_bank      out  1      bank the display reads; the write bank is always ~rd_bank
//  busy         out  1      a frame build is in progress
//  frame_done   out  1      one-cycle pulse after the last column is written
//  overrun      out  1      one-cycle pulse: frame_start arrived while busy
// BEHAVIOUR
//  Reset values (asynchronous): state=IDLE, col=0, rd_bank=0, ready=0. Every output is 0.
//  FSM states: IDLE -> REQ -> WRITE -> (REQ | DONE) -> IDLE.
//  IDLE
//   - On frame_start: if ready=1, toggle rd_bank and clear ready.
//   - In the same cycle: col<=0, go to REQ. busy=1 from the next cycle.
//   - With ready=0 (first frame after reset) rd_bank is unchanged; the build targets bank 1.
//  REQ
//   - ray_req=1 and ray_col=col, held until the ray_ack cycle (that cycle included).
//   - ray_ack may arrive in the first REQ cycle. ray_ack outside REQ is ignored.
//   - On ack: latch data, clamping height to min(ray_height, MAX_HALF). Go to WRITE.
//  WRITE
//   - wr_en=1 for exactly one cycle, with wr_addr={~rd_bank,col}.
//   - If col==NUM_COLS-1 go to DONE; otherwise col<=col+1 and go to REQ.
//  DONE
//   - frame_done=1 for one cycle, ready<=1, go to IDLE. busy=0 from the next cycle.
//  Minimum time per column: 2 cycles (REQ with immediate ack, then WRITE). No wrap past NUM_COLS-1.
//  frame_start while busy (REQ/WRITE/DONE): overrun pulses and the start is dropped.
//   rd_bank is unchanged and the build continues to completion.
//   The swap happens at the next frame_start seen in IDLE.
//  frame_start and DONE in the same cycle: counts as an overrun. No swap that cycle.
//  Reset mid-build: returns to IDLE immediately; the partial bank is never shown (ready=0).
//  col is COL_W bits wide; arithmetic is unsigned. The clamp is an unsigned 8-bit compare.
// CONFIGURATION
//  RAY_STATS_EN defined
//   - Adds output frame_cycles [19:0]: Clk count from the IDLE->REQ transition to the DONE cycle.
//   - The value is updated at DONE, saturates at 20'hFFFFF and resets to 0.
//  RAY_STATS_EN undefined: the port and the counter are absent. All other behaviour is identical.
// STRUCTURE
//  raycast_pkg
//   - state_t enum {IDLE,REQ,WRITE,DONE}.
//   - Constants NUM_COLS, COL_W and Y_CENTER=240.
//   - Field positions MEM_SHADE=[11:8] and MEM_HEIGHT=[7:0], shared with the color mapper.
//  Sub-module: none. This is a single FSM plus the col counter.
//  The column RAM lives outside this block.
// TESTING
//  T1 reset: hold reset_n=0 mid-REQ -> all outputs 0 at once, rd_bank=0. After release, state=IDLE.
//  T2 frame build: stub acks after 3 cycles
//   - Expect 640 writes at wr_addr={1,0..639} in order, then one frame_done.
//   - rd_bank stays 0 until the next frame_start, then becomes 1.
//  T3 timing and clamp: immediate ack -> 2 cycles per column.
//   - Column 5: height 250 -> wr_data[7:0]=239. Column 6: height 100 -> 100.
//  T4 overrun: frame_start at column 300 -> one overrun pulse and writes continue.
//   - rd_bank is unchanged; the swap happens at the following frame_start.
//  T5 ack discipline: ray_ack pulsed while in IDLE -> no write.
//   - ray_col is stable through REQ. ray_req drops in the cycle after ack.
//  T6 RAY_STATS_EN: 640 columns with 3-cycle ack latency -> frame_cycles=2560 (640x4).

Source files
------------

// File: rtl/raycast_pkg.sv
`default_nettype none
// =============================================================================
//  Module   : raycast_pkg
//  Purpose  : Shared types and constants for the raycast column pipeline
//             (scheduler FSM states, column geometry, column-RAM field layout).
//  Revision : 1.0  initial release
// =============================================================================
package raycast_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_COLS = 640;
    localparam int COL_W    = 10;
    localparam int Y_CENTER = 240;

    // Column RAM word layout, also decoded by the color mapper
    localparam int MEM_SHADE_HI  = 11;
    localparam int MEM_SHADE_LO  = 8;
    localparam int MEM_HEIGHT_HI = 7;
    localparam int MEM_HEIGHT_LO = 0;

    function automatic logic [7:0] clamp_half(input logic [7:0] h, input logic [7:0] lim);
        return (h > lim) ? lim : h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ray_column_scheduler.sv
`default_nettype none
// =============================================================================
//  Module   : ray_column_scheduler
//  Purpose  : Requests one ray per screen column each frame and writes
//             {shade, clamped half height} into a double-buffered column RAM.
//             Optional macro RAY_STATS_EN adds the frame_cycles build counter.
//  Revision : 1.0  initial release
// =============================================================================
module ray_column_scheduler #(
    parameter int         NUM_COLS = raycast_pkg::NUM_COLS,
    parameter int         COL_W    = raycast_pkg::COL_W,
    parameter logic [7:0] MAX_HALF = 8'd239
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             frame_start,
    output logic             ray_req,
    output logic [COL_W-1:0] ray_col,
    input  logic             ray_ack,
    input  logic [7:0]       ray_height,
    input  logic [3:0]       ray_shade,
    output logic             wr_en,
    output logic [COL_W:0]   wr_addr,
    output logic [11:0]      wr_data,
    output logic             rd_bank,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
`ifdef RAY_STATS_EN
    ,
    output logic [19:0]      frame_cycles
`endif
);
    import raycast_pkg::*;

    localparam logic [COL_W-1:0] c_last_col = COL_W'(NUM_COLS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [COL_W-1:0]  r_col;
    logic              r_rd_bank;
    logic              r_ready;
    logic [11:0]       r_data;
    logic              r_overrun;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ray_req     = 1'b0;
        wr_en       = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                ray_req = 1'b1;
                if (ray_ack) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en       = 1'b1;
                w_state_nxt = (r_col == c_last_col) ? DONE : REQ;
            end
            DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The swap only happens on a start accepted in IDLE after a completed build,
    // so a dropped (overrun) start never exposes a partial bank.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col     <= '0;
            r_rd_bank <= 1'b0;
            r_ready   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= frame_start && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_col <= '0;
                        if (r_ready) begin
                            r_rd_bank <= ~r_rd_bank;
                            r_ready   <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (ray_ack) begin
                        r_data[MEM_SHADE_HI:MEM_SHADE_LO]   <= ray_shade;
                        r_data[MEM_HEIGHT_HI:MEM_HEIGHT_LO] <= clamp_half(ray_height, MAX_HALF);
                    end
                end
                WRITE: begin
                    if (r_col != c_last_col) begin
                        r_col <= r_col + 1'b1;
                    end
                end
                DONE: begin
                    r_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ray_col = r_col;
    assign wr_addr = wr_en ? {~r_rd_bank, r_col} : '0;
    assign wr_data = wr_en ? r_data : '0;
    assign rd_bank = r_rd_bank;
    assign busy    = (r_state != IDLE);
    assign overrun = r_overrun;

`ifdef RAY_STATS_EN
    logic [19:0] r_cyc_cnt;
    logic [19:0] r_frame_cycles;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc_cnt      <= '0;
            r_frame_cycles <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_cyc_cnt <= '0;
                    end
                end
                REQ, WRITE: begin
                    if (r_cyc_cnt != 20'hFFFFF) begin
                        r_cyc_cnt <= r_cyc_cnt + 20'd1;
                    end
                end
                DONE: begin
                    r_frame_cycles <= r_cyc_cnt;
                end
                default: ;
            endcase
        end
    end

    assign frame_cycles = r_frame_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ray_column_scheduler.sv
`default_nettype none
// =============================================================================
//  Module   : tb_ray_column_scheduler
//  Purpose  : Self-checking bench for ray_column_scheduler with a randomized
//             ray-engine stub and a frame-level reference model.
//  Revision : 1.0  initial release
// =============================================================================
module tb_ray_column_scheduler;

    localparam int NCOLS = 640;
    localparam int MAXH  = 239;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        ray_ack = 1'b0;
    logic [7:0]  ray_height = 8'd0;
    logic [3:0]  ray_shade = 4'd0;
    logic        ray_req;
    logic [9:0]  ray_col;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [11:0] wr_data;
    logic        rd_bank;
    logic        busy;
    logic        frame_done;
    logic        overrun;
`ifdef RAY_STATS_EN
    logic [19:0] frame_cycles;
`endif

    int errors = 0;
    int checks = 0;

    // Reference view of the display-side state
    bit m_rd_bank = 1'b0;
    bit m_ready   = 1'b0;

    ray_column_scheduler dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .ray_req     (ray_req),
        .ray_col     (ray_col),
        .ray_ack     (ray_ack),
        .ray_height  (ray_height),
        .ray_shade   (ray_shade),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_bank     (rd_bank),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
`ifdef RAY_STATS_EN
        ,
        .frame_cycles(frame_cycles)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] ref_clamp(input int h);
        return (h > MAXH) ? 8'(MAXH) : 8'(h);
    endfunction

    task automatic check_all_zero(input string tag);
        checks++;
        if ({ray_req, ray_col, wr_en, wr_addr, wr_data, rd_bank, busy, frame_done, overrun} !== '0) begin
            errors++;
            $display("FAIL %s outputs: req=%b col=%0d wr_en=%b addr=%h data=%h rd_bank=%b busy=%b done=%b ovr=%b, required all 0",
                     tag, ray_req, ray_col, wr_en, wr_addr, wr_data, rd_bank, busy, frame_done, overrun);
        end
    endtask

    // One frame build: lat=0 picks a random 1..4 cycle ack latency per column.
    // ovr_col>=0 injects a frame_start after that column's write (NCOLS = during DONE).
    task automatic run_frame(input int lat, input int ovr_col, input bit noise, input string tag);
        logic [7:0] h_ref [NCOLS];
        logic [3:0] s_ref [NCOLS];
        int  col_exp = 0;
        int  req_cnt = 0;
        int  lat_i;
        int  busy_cycles = 0;
        int  exp_busy = 1;
        int  ovr_pulses = 0;
        int  cyc = 0;
        int  hh;
        bit  done = 1'b0;
        bit  wb;

        if (m_ready) begin
            m_rd_bank = ~m_rd_bank;
            m_ready   = 1'b0;
        end
        wb = ~m_rd_bank;
        lat_i = (lat == 0) ? int'($urandom_range(1, 4)) : lat;

        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        checks++;
        if (rd_bank !== m_rd_bank) begin
            errors++;
            $display("FAIL %s rd_bank_at_start got=%b exp=%b", tag, rd_bank, m_rd_bank);
        end

        while (!done && cyc < 20000) begin
            cyc++;
            ray_ack = 1'b0;
            frame_start = 1'b0;
            if (overrun) ovr_pulses++;
            if (busy) busy_cycles++;
            if (wr_en) begin
                checks++;
                if (ray_req !== 1'b0 || col_exp >= NCOLS ||
                    wr_addr !== {wb, 10'(col_exp)} || wr_data !== {s_ref[col_exp], ref_clamp(int'(h_ref[col_exp]))}) begin
                    errors++;
                    $display("FAIL %s write col=%0d got addr=%h data=%h req=%b exp addr=%h data=%h req=0",
                             tag, col_exp, wr_addr, wr_data, ray_req, {wb, 10'(col_exp)},
                             (col_exp < NCOLS) ? {s_ref[col_exp], ref_clamp(int'(h_ref[col_exp]))} : 12'h0);
                end
                exp_busy += lat_i + 1;
                if (col_exp == ovr_col) frame_start = 1'b1;
                col_exp++;
                req_cnt = 0;
                lat_i = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
                if (noise) begin
                    ray_ack    = 1'b1;
                    ray_height = 8'($urandom);
                    ray_shade  = 4'($urandom);
                end
            end else if (ray_req) begin
                checks++;
                if (ray_col !== 10'(col_exp)) begin
                    errors++;
                    $display("FAIL %s ray_col got=%0d exp=%0d", tag, ray_col, col_exp);
                end
                req_cnt++;
                if (req_cnt == lat_i && col_exp < NCOLS) begin
                    case (col_exp)
                        5:       hh = 250;
                        6:       hh = 100;
                        7:       hh = 239;
                        8:       hh = 240;
                        default: hh = int'($urandom_range(0, 255));
                    endcase
                    h_ref[col_exp] = 8'(hh);
                    s_ref[col_exp] = 4'($urandom);
                    ray_height = h_ref[col_exp];
                    ray_shade  = s_ref[col_exp];
                    ray_ack    = 1'b1;
                end else if (noise) begin
                    ray_height = 8'($urandom);
                    ray_shade  = 4'($urandom);
                end
            end else if (frame_done) begin
                done = 1'b1;
                checks++;
                if (col_exp != NCOLS) begin
                    errors++;
                    $display("FAIL %s writes_before_done got=%0d exp=%0d", tag, col_exp, NCOLS);
                end
                if (ovr_col == NCOLS) frame_start = 1'b1;
            end
            @(negedge Clk);
        end
        ray_ack = 1'b0;
        frame_start = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout waiting for frame_done after %0d cycles", tag, cyc);
        end
        if (overrun) ovr_pulses++;
        checks++;
        if (ovr_pulses != ((ovr_col >= 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s overrun_pulses got=%0d exp=%0d", tag, ovr_pulses, (ovr_col >= 0) ? 1 : 0);
        end
        checks++;
        if (busy !== 1'b0 || busy_cycles != exp_busy) begin
            errors++;
            $display("FAIL %s busy after=%b cycles got=%0d exp=%0d", tag, busy, busy_cycles, exp_busy);
        end
        checks++;
        if (rd_bank !== m_rd_bank) begin
            errors++;
            $display("FAIL %s rd_bank_after got=%b exp=%b", tag, rd_bank, m_rd_bank);
        end
`ifdef RAY_STATS_EN
        checks++;
        if (frame_cycles !== 20'(exp_busy - 1)) begin
            errors++;
            $display("FAIL %s frame_cycles got=%0d exp=%0d", tag, frame_cycles, exp_busy - 1);
        end
`endif
        m_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check_all_zero("reset_hold");
        reset_n = 1'b1;
        @(negedge Clk);
        check_all_zero("reset_release");
        m_rd_bank = 1'b0;
        m_ready   = 1'b0;
    endtask

    task automatic test_frame_build;
        run_frame(3, -1, 1'b0, "build_lat3");
        repeat (5) @(negedge Clk);
        checks++;
        if (rd_bank !== 1'b0) begin
            errors++;
            $display("FAIL build_idle rd_bank got=%b exp=0", rd_bank);
        end
    endtask

    task automatic test_clamp_timing;
        run_frame(1, -1, 1'b0, "immediate_ack");
    endtask

    task automatic test_overrun;
        run_frame(0, 300, 1'b1, "overrun_mid");
        repeat (2) @(negedge Clk);
        run_frame(1, NCOLS, 1'b0, "overrun_at_done");
        @(negedge Clk);
        checks++;
        if (busy !== 1'b0 || rd_bank !== m_rd_bank) begin
            errors++;
            $display("FAIL overrun_dropped busy=%b rd_bank=%b exp busy=0 rd_bank=%b", busy, rd_bank, m_rd_bank);
        end
        run_frame(2, -1, 1'b1, "swap_after_overrun");
    endtask

    task automatic test_ack_idle;
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            ray_ack    = 1'($urandom);
            ray_height = 8'($urandom);
            ray_shade  = 4'($urandom);
            @(negedge Clk);
            if (wr_en !== 1'b0 || ray_req !== 1'b0 || busy !== 1'b0) bad++;
        end
        ray_ack = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ack_in_idle active_cycles got=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_mid_build;
        int guard = 0;
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        repeat (7) @(negedge Clk);
        while (!ray_req && guard < 50) begin
            guard++;
            @(negedge Clk);
        end
        checks++;
        if (ray_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid no REQ reached got ray_req=%b exp=1", ray_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_async");
        @(negedge Clk);
        reset_n = 1'b1;
        m_rd_bank = 1'b0;
        m_ready   = 1'b0;
        @(negedge Clk);
        check_all_zero("reset_mid_release");
        run_frame(2, -1, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_frame_build();
        test_clamp_timing();
        test_overrun();
        test_ack_idle();
        test_reset_mid_build();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
